bcd_serial_sub: RTL

Digit-serial, multi-digit BCD subtractor producing a sign-magnitude BCD difference. It is the subtraction counterpart of the team's one-digit BCD adder. It accepts two packed BCD operands on a start strobe and processes one digit per clock, least-significant digit first. If the raw result is negative, a second pass converts the ten's-complement result to a magnitude. It sits between the keypad/operand registers and the BCD display path of the calculator datapath.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_serial_sub_if.sv | 34 +++
 rtl/bcd_digit_sub.sv | 27 ++
 rtl/bcd_serial_sub.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit value, the
// serial subtractor state encoding and a digit-validity helper.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    // Serial subtractor sequencing states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // True when a 4-bit code is a legal decimal digit (0..9).
    function automatic logic digit_ok(input logic [BCD_W-1:0] dig);
        return dig <= BCD_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_sub_if.sv
// Operand/result bundle of the digit-serial BCD subtractor.
//
// Handshake: the requester drives a, b and raises start for one cycle while
// busy and done are both low (the subtractor is idle). The subtractor then
// runs, holds busy high, and finally raises done for exactly one cycle. diff,
// neg and invalid are valid from the done cycle until the next accepted start.
// start is ignored while busy or done is high; requests are never queued.
// state mirrors the internal sequencer for observation only.
interface bcd_serial_sub_if #(
    parameter int DIGITS = 4
);
    import bcd_pkg::*;

    logic                    start;
    logic [BCD_W*DIGITS-1:0] a;
    logic [BCD_W*DIGITS-1:0] b;
    logic                    busy;
    logic                    done;
    logic [BCD_W*DIGITS-1:0] diff;
    logic                    neg;
    logic                    invalid;
    state_t                  state;

    modport master (
        output start, a, b,
        input  busy, done, diff, neg, invalid, state
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, neg, invalid, state
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtractor with borrow: d = x - y - bin, folded back into
// 0..9 by adding ten when the raw difference goes negative.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             bin,
    output logic [BCD_W-1:0] d,
    output logic             bout
);

    localparam logic signed [BCD_W:0] TEN = (BCD_W+1)'(10);

    logic signed [BCD_W:0] raw;
    logic signed [BCD_W:0] adj;

    // Raw signed difference spans -10..9; negative values borrow from the
    // next digit and are corrected by +10.
    always_comb begin
        raw  = signed'({1'b0, x}) - signed'({1'b0, y}) - signed'({{BCD_W{1'b0}}, bin});
        adj  = raw + TEN;
        bout = raw[BCD_W];
        d    = bout ? adj[BCD_W-1:0] : raw[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial multi-digit BCD subtractor with sign-magnitude result.
// One digit per clock, least-significant first. A negative raw result
// (final borrow out) triggers a second pass that ten's-complements the
// stored digits in place to recover the magnitude.
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic             clk,
    input  logic             rst,
    bcd_serial_sub_if.slave  bus
);

    localparam int                W     = BCD_W * DIGITS;
    localparam int                IDX_W = $clog2(DIGITS) + 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DIGITS - 1);

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     diff_q;
    logic [IDX_W-1:0] idx;
    logic             borrow;
    logic             busy_q;
    logic             done_q;
    logic             neg_q;
    logic             invalid_q;

    logic             ops_ok;
    logic [BCD_W-1:0] a_dig;
    logic [BCD_W-1:0] b_dig;
    logic [BCD_W-1:0] diff_dig;
    logic [BCD_W-1:0] sub_x;
    logic [BCD_W-1:0] sub_y;
    logic [BCD_W-1:0] sub_d;
    logic             sub_bout;

    // Screen the incoming operands; only meaningful on the start edge in IDLE.
    always_comb begin
        ops_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!digit_ok(bus.a[k*BCD_W +: BCD_W]) || !digit_ok(bus.b[k*BCD_W +: BCD_W]))
                ops_ok = 1'b0;
        end
    end

    // Select the current digit and feed the shared digit subtractor:
    // SUB computes a_k - b_k, NEG computes 0 - diff_k.
    always_comb begin
        a_dig    = a_q[idx*BCD_W +: BCD_W];
        b_dig    = b_q[idx*BCD_W +: BCD_W];
        diff_dig = diff_q[idx*BCD_W +: BCD_W];
        sub_x    = (state == S_NEG) ? '0 : a_dig;
        sub_y    = (state == S_NEG) ? diff_dig : b_dig;
    end

    bcd_digit_sub u_digit (
        .x    (sub_x),
        .y    (sub_y),
        .bin  (borrow),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // Sequencer, operand/result registers, borrow and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        diff_q <= '0;
                        idx    <= '0;
                        borrow <= 1'b0;
                        neg_q  <= 1'b0;
                        if (ops_ok) begin
                            invalid_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state     <= S_SUB;
                        end else begin
                            invalid_q <= 1'b1;
                            done_q    <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_SUB: begin
                    diff_q[idx*BCD_W +: BCD_W] <= sub_d;
                    if (idx == LAST) begin
                        idx <= '0;
                        if (sub_bout) begin
                            // Raw result negative: start the complement pass.
                            borrow <= 1'b0;
                            state  <= S_NEG;
                        end else begin
                            borrow <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end else begin
                        borrow <= sub_bout;
                        idx    <= idx + 1'b1;
                    end
                end
                S_NEG: begin
                    diff_q[idx*BCD_W +: BCD_W] <= sub_d;
                    if (idx == LAST) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        neg_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        borrow <= sub_bout;
                        idx    <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.diff    = diff_q;
    assign bus.neg     = neg_q;
    assign bus.invalid = invalid_q;
    assign bus.state   = state;

endmodule
